// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_controller_tx between NUM_REQ byte producers. Each byte goes
// through a fixed sequence: round-robin grant, one-cycle send strobe, wait for
// the transmitter's done pulse (bounded by a timeout), then a forced idle gap.
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-high reset
//   req_i         - level request per requester, held until its ack
//   req_data_i    - byte of requester i on bits [8i+7:8i]
//   ack_o         - one-cycle pulse: requester's byte has been captured
//   tx_send_o     - one-cycle start strobe to the UART transmitter
//   tx_data_o     - byte to the transmitter, stable until done/timeout
//   tx_done_i     - one-cycle completion pulse from the transmitter
//   busy_o        - high whenever the arbiter is not idle
//   last_grant_o  - index of the most recently granted requester
//   timeout_err_o - sticky flag, set when done never arrived in time
//   err_clr_i     - synchronous clear of timeout_err_o (a new timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int CNT_W          = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 tx_send_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic [2:0]           last_grant_o,
  output logic                 timeout_err_o,
  input  logic                 err_clr_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Last counter value of each timed state; a zero-length gap still spends
  // one cycle in GAP, so its terminal count is 0.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES == 32'sd0) ? {CNT_W{1'b0}}
                                                                 : CNT_W'(GAP_CYCLES - 32'sd1);

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [1:0]         state_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               send_nxt_s;
  logic [NUM_REQ-1:0] ack_nxt_s;
  logic [7:0]         data_nxt_s;
  logic [2:0]         grant_nxt_s;
  logic               to_set_s;

  logic [7:0]         req_pad_s;
  logic [63:0]        data_pad_s;
  logic [3:0]         cand_s;
  logic [2:0]         sel_idx_s;
  logic               sel_found_s;
  logic [7:0]         sel_data_s;

  // Pad request and data buses to the 8-requester maximum so selection can
  // index them with a plain 3-bit requester number.
  assign req_pad_s  = 8'(req_i);
  assign data_pad_s = 64'(req_data_i);
  assign sel_data_s = data_pad_s[{sel_idx_s, 3'b000} +: 8];

  // Saturating increment shared by the WAIT and GAP counters.
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1'b1);

  // Round-robin search: first set request starting just above the last grant,
  // wrapping modulo NUM_REQ, so the last winner is considered last.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = last_grant_o;
    cand_s      = 4'd0;
    for (int k = 32'sd0; k < NUM_REQ; k++) begin
      cand_s = 4'(last_grant_o) + 4'(k) + 4'd1;
      if (cand_s >= 4'(NUM_REQ)) begin
        cand_s = cand_s - 4'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!sel_found_s && req_pad_s[cand_s[2:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[2:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state, counter and output-strobe decode for the byte sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    send_nxt_s  = 1'b0;
    ack_nxt_s   = {NUM_REQ{1'b0}};
    data_nxt_s  = tx_data_o;
    grant_nxt_s = last_grant_o;
    to_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          // Strobe and ack are registered here so they are high exactly
          // during the SEND cycle.
          state_nxt_s = ST_SEND;
          send_nxt_s  = 1'b1;
          ack_nxt_s   = NUM_REQ'(1'b1) << sel_idx_s;
          data_nxt_s  = sel_data_s;
          grant_nxt_s = sel_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_nxt_s = ST_WAIT;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      ST_WAIT: begin
        // Done is tested first so a done on the last allowed cycle is not
        // reported as a timeout.
        if (tx_done_i) begin
          state_nxt_s = ST_GAP;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = ST_GAP;
          cnt_nxt_s   = {CNT_W{1'b0}};
          to_set_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      ST_GAP: begin
        if (cnt_r >= GAP_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and all registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      busy_o        <= 1'b0;
      tx_send_o     <= 1'b0;
      ack_o         <= {NUM_REQ{1'b0}};
      tx_data_o     <= 8'h00;
      last_grant_o  <= 3'(NUM_REQ - 32'sd1);
      timeout_err_o <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      busy_o        <= (state_nxt_s != ST_IDLE);
      tx_send_o     <= send_nxt_s;
      ack_o         <= ack_nxt_s;
      tx_data_o     <= data_nxt_s;
      last_grant_o  <= grant_nxt_s;
      if (to_set_s) begin
        timeout_err_o <= 1'b1;
      end else if (err_clr_i) begin
        timeout_err_o <= 1'b0;
      end else begin
        timeout_err_o <= timeout_err_o;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: stimulus pushes the expected (ack, byte, grant) of every
// strobe into a queue; a monitor pops and compares whenever tx_send_o is seen.
// Timing-related expectations (busy, timeout flag) are checked inline.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int GAP     = 2;
  localparam int TO      = 10;
  localparam int CNT_W   = 18;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_i = 4'b0000;
  logic [31:0]  req_data = 32'h0;
  logic [3:0]   ack_o;
  logic         tx_send_o;
  logic [7:0]   tx_data_o;
  logic         tx_done_i = 1'b0;
  logic         busy_o;
  logic [2:0]   last_grant_o;
  logic         timeout_err_o;
  logic         err_clr_i = 1'b0;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
    logic [2:0] grant;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   order[3];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_data_i(req_data),
    .ack_o(ack_o), .tx_send_o(tx_send_o), .tx_data_o(tx_data_o),
    .tx_done_i(tx_done_i), .busy_o(busy_o), .last_grant_o(last_grant_o),
    .timeout_err_o(timeout_err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_send(input string name, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (tx_send_o === 1'b1) seen = 1'b1;
    end
    check({name, "_send_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_done();
    tx_done_i = 1'b1;
    @(negedge clk);
    tx_done_i = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d, input logic [2:0] g);
    exp_t e;
    e.ack = a; e.data = d; e.grant = g;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard queue; no ack
  // may appear without a strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_send_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_send: got strobe with data %0h ack %b, required no strobe",
                   tx_data_o, ack_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("mon_ack",   32'(ack_o),        32'(mon_e.ack));
          check("mon_data",  32'(tx_data_o),    32'(mon_e.data));
          check("mon_grant", 32'(last_grant_o), 32'(mon_e.grant));
        end
      end else begin
        check("mon_ack_idle", 32'(ack_o), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    tick(2);
    check("rst_send",  32'(tx_send_o),     32'd0);
    check("rst_ack",   32'(ack_o),         32'd0);
    check("rst_data",  32'(tx_data_o),     32'h00);
    check("rst_grant", 32'(last_grant_o),  32'd3);
    check("rst_err",   32'(timeout_err_o), 32'd0);
    check("rst_busy",  32'(busy_o),        32'd0);
    reset = 1'b0;

    // Single request, done 5 cycles after the strobe
    set_lane(2, 8'hA5);
    req_i = 4'b0100;
    push(4'b0100, 8'hA5, 3'd2);
    tick(1);
    check("t1_strobe", 32'(tx_send_o), 32'd1);
    check("t1_ack",    32'(ack_o),     32'h4);
    check("t1_busy",   32'(busy_o),    32'd1);
    req_i = 4'b0000;
    tick(4);
    check("t1_data_stable", 32'(tx_data_o), 32'hA5);
    check("t1_send_low",    32'(tx_send_o), 32'd0);
    pulse_done();
    check("t1_gap0_busy", 32'(busy_o), 32'd1);
    tick(1);
    check("t1_gap1_busy", 32'(busy_o), 32'd1);
    tick(1);
    check("t1_idle_busy", 32'(busy_o),       32'd0);
    check("t1_grant",     32'(last_grant_o), 32'd2);

    // Contention: 0, 1, 3 from a fresh reset
    apply_reset();
    set_lane(0, 8'h10); set_lane(1, 8'h11); set_lane(2, 8'hEE); set_lane(3, 8'h13);
    order[0] = 0; order[1] = 1; order[2] = 3;
    push(4'b0001, 8'h10, 3'd0);
    push(4'b0010, 8'h11, 3'd1);
    push(4'b1000, 8'h13, 3'd3);
    req_i = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      wait_send("t2", 10);
      req_i[order[i]] = 1'b0;
      tick(1);
      pulse_done();
    end
    tick(4);
    check("t2_idle",  32'(busy_o),       32'd0);
    check("t2_drain", 32'(exp_q.size()), 32'd0);

    // Fairness: 0 and 1 held continuously must alternate
    set_lane(0, 8'h20); set_lane(1, 8'h21);
    push(4'b0001, 8'h20, 3'd0);
    push(4'b0010, 8'h21, 3'd1);
    push(4'b0001, 8'h20, 3'd0);
    push(4'b0010, 8'h21, 3'd1);
    req_i = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_send("t3", 10);
      if (i == 3) req_i = 4'b0000;
      tick(1);
      pulse_done();
    end
    tick(4);
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // Timeout: no done, flag rises 10 cycles after WAIT entry
    set_lane(2, 8'h3C);
    push(4'b0100, 8'h3C, 3'd2);
    req_i = 4'b0100;
    wait_send("t4", 10);
    req_i = 4'b0000;
    tick(10);
    check("t4_err_before", 32'(timeout_err_o), 32'd0);
    tick(1);
    check("t4_err_set",  32'(timeout_err_o), 32'd1);
    check("t4_gap_busy", 32'(busy_o),        32'd1);
    set_lane(0, 8'h77);
    push(4'b0001, 8'h77, 3'd0);
    req_i = 4'b0001;
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    check("t4_late_done_busy", 32'(busy_o),        32'd1);
    check("t4_late_done_err",  32'(timeout_err_o), 32'd1);
    tick(1);
    check("t4_idle", 32'(busy_o), 32'd0);
    tick(1);
    check("t4_regrant", 32'(tx_send_o), 32'd1);
    req_i = 4'b0000;
    tick(1);
    pulse_done();
    tick(3);
    check("t4_sticky", 32'(timeout_err_o), 32'd1);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("t4_cleared", 32'(timeout_err_o), 32'd0);

    // Reset in the middle of WAIT_DONE
    set_lane(1, 8'h42);
    push(4'b0010, 8'h42, 3'd1);
    req_i = 4'b0010;
    wait_send("t5", 10);
    set_lane(0, 8'h99);
    req_i = 4'b0001;
    tick(2);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_send",  32'(tx_send_o),     32'd0);
    check("t5_rst_ack",   32'(ack_o),         32'd0);
    check("t5_rst_data",  32'(tx_data_o),     32'h00);
    check("t5_rst_grant", 32'(last_grant_o),  32'd3);
    check("t5_rst_busy",  32'(busy_o),        32'd0);
    check("t5_rst_err",   32'(timeout_err_o), 32'd0);
    tick(1);
    push(4'b0001, 8'h99, 3'd0);
    reset = 1'b0;
    tick(1);
    check("t5_after_reset", 32'(tx_send_o), 32'd1);
    req_i = 4'b0000;
    tick(1);
    pulse_done();
    tick(3);

    // Stray done in IDLE changes nothing
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    check("t6_stray_busy",  32'(busy_o),        32'd0);
    check("t6_stray_grant", 32'(last_grant_o),  32'd0);
    check("t6_stray_err",   32'(timeout_err_o), 32'd0);

    // Done coincident with the last timeout cycle: done wins
    set_lane(3, 8'hC3);
    push(4'b1000, 8'hC3, 3'd3);
    req_i = 4'b1000;
    wait_send("t6", 10);
    req_i = 4'b0000;
    tick(10);
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    check("t6_coinc_err",  32'(timeout_err_o), 32'd0);
    check("t6_coinc_busy", 32'(busy_o),        32'd1);
    tick(2);
    check("t6_coinc_idle", 32'(busy_o),        32'd0);
    check("final_drain",   32'(exp_q.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
